// File: rtl/ahb_slave_mem_param.sv
// ahb_slave_mem_param
//   Parametrised AHB-Lite slave memory with programmable wait states,
//   byte/halfword/word(/dword) lanes and a two-cycle ERROR response.
//
//   Optional feature macro: AHB_SLV_PROT_EN
//     defined   : user-mode (hprot[1]=0) writes to the upper half of memory
//                 are rejected with an ERROR response.
//     undefined : hprot is ignored.
//
// Ports
//   hclk    in   bus clock, rising edge
//   hreset  in   asynchronous active-high reset
//   hsel    in   slave select
//   haddr   in   byte address [ADDR_WIDTH]
//   htrans  in   IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
//   hwrite  in   1 = write
//   hsize   in   0 byte, 1 half, 2 word, 3 dword
//   hburst  in   accepted, not decoded
//   hprot   in   protection (optional feature only)
//   hwdata  in   write data [DATA_WIDTH], valid in data phase
//   hrdata  out  read data [DATA_WIDTH]
//   hready  out  transfer done / slave ready
//   hresp   out  0 OKAY, 1 ERROR
//   error   out  sticky ERROR flag, cleared only by reset
module ahb_slave_mem_param #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hready,
  output logic                  hresp,
  output logic                  error
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(NBYTES);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned LOW_W  = OFF_W + IDX_W;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  logic [2:0]            r_state;
  logic [3:0]            r_cnt;
  logic [LOW_W-1:0]      r_addr;
  logic                  r_write;
  logic [2:0]            r_size;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_hrdata;
  logic                  r_error;

  logic                  w_accept;
  logic                  w_size_ok;
  logic                  w_misalign;
  logic                  w_oor;
  logic                  w_prot_viol;
  logic                  w_illegal;
  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W-1:0]      r_idx_w;
  logic [2:0]            w_next;
  logic [NBYTES-1:0]     w_be;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_wr_word;
  logic                  w_rd_load;
  logic [IDX_W-1:0]      w_rd_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_unused;

  assign hready = ~((r_state == S_WAIT) | (r_state == S_ERR1));
  assign hresp  = (r_state == S_ERR1) | (r_state == S_ERR2);
  assign hrdata = r_hrdata;
  assign error  = r_error;

  assign w_accept = hsel & htrans[1] & hready;
  assign w_idx    = haddr[OFF_W +: IDX_W];
  assign r_idx_w  = r_addr[OFF_W +: IDX_W];

  // Legality of the transfer presented in the address phase.
  assign w_size_ok = ({29'd0, hsize} <= OFF_W);
  assign w_oor     = |haddr[ADDR_WIDTH-1:LOW_W];

  always_comb begin
    w_misalign = 1'b0;
    for (int unsigned b = 0; b < OFF_W; b++) begin
      if ((b < 32'(hsize)) && haddr[b]) w_misalign = 1'b1;
    end
  end

`ifdef AHB_SLV_PROT_EN
  assign w_prot_viol = hwrite & ~hprot[1] & w_idx[IDX_W-1];
`else
  assign w_prot_viol = 1'b0;
`endif

  assign w_illegal = ~w_size_ok | w_misalign | w_oor | w_prot_viol;

  // IDLE, DATA and ERR2 all drive hready=1, so they share acceptance rules.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT:  if (r_cnt == '0) w_next = S_DATA;
      S_ERR1:  w_next = S_ERR2;
      default: begin
        if (w_accept) begin
          if (w_illegal)            w_next = S_ERR1;
          else if (WAIT_STATES > 0) w_next = S_WAIT;
          else                      w_next = S_DATA;
        end else begin
          w_next = S_IDLE;
        end
      end
    endcase
  end

  // Lane b is selected when it falls in the same 2^size-byte group as the
  // (aligned) transfer address.
  always_comb begin
    w_be = '0;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      w_be[b] = ((b >> r_size) == (32'(r_addr[OFF_W-1:0]) >> r_size));
    end
  end

  assign w_wr_en = (r_state == S_DATA) & r_write;

  always_comb begin
    w_wr_word = '0;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      w_wr_word[8*b +: 8] = w_be[b] ? hwdata[8*b +: 8] : r_mem[r_idx_w][8*b +: 8];
    end
  end

  // Read data is captured on the edge entering DATA. With zero wait states
  // that edge may also commit a write to the same word, so forward the
  // merged word instead of the stale array content.
  assign w_rd_load = (w_next == S_DATA) & ((r_state == S_WAIT) ? ~r_write : ~hwrite);
  assign w_rd_idx  = (r_state == S_WAIT) ? r_idx_w : w_idx;
  assign w_rd_word = (w_wr_en && (r_idx_w == w_rd_idx)) ? w_wr_word : r_mem[w_rd_idx];

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_size   <= '0;
      r_hrdata <= '0;
      r_error  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= haddr[LOW_W-1:0];
        r_write <= hwrite;
        r_size  <= hsize;
      end
      if ((w_next == S_WAIT) && (r_state != S_WAIT)) r_cnt <= 4'(WAIT_STATES - 1);
      else if (r_state == S_WAIT)                    r_cnt <= r_cnt - 4'd1;
      if (w_rd_load)            r_hrdata <= w_rd_word;
      if (r_state == S_ERR1)    r_error  <= 1'b1;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[r_idx_w] <= w_wr_word;
    end
  end

  assign w_unused = ^{htrans[0], hburst, hprot};

endmodule
